// File: rtl/serial_bus_pkg.sv
// Shared definitions for the bit-serial bus: default widths, target states,
// bus_mode and read/write encodings.
package serial_bus_pkg;

    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WDATA = 3'd1,
        RWAIT = 3'd2,
        SPLIT = 3'd3,
        RTX   = 3'd4
    } tgt_state_e;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_DATA = 1'b1;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/serial_bus_if.sv
// Bit-serial bus between initiator (master) and target (slave); the clock and
// reset are carried outside the interface.
interface serial_bus_if;

    logic bus_data_in;
    logic bus_data_in_valid;
    logic bus_mode;
    logic bus_init_rw;
    logic bus_init_ready;
    logic split_resume;
    logic bus_data_out;
    logic bus_data_out_valid;
    logic target_ack;
    logic target_split;

    modport master (
        output bus_data_in,
        output bus_data_in_valid,
        output bus_mode,
        output bus_init_rw,
        output bus_init_ready,
        output split_resume,
        input  bus_data_out,
        input  bus_data_out_valid,
        input  target_ack,
        input  target_split
    );

    modport slave (
        input  bus_data_in,
        input  bus_data_in_valid,
        input  bus_mode,
        input  bus_init_rw,
        input  bus_init_ready,
        input  split_resume,
        output bus_data_out,
        output bus_data_out_valid,
        output target_ack,
        output target_split
    );

endinterface

// File: rtl/bus_bit_deser.sv
// LSB-first serial-to-parallel collector: one bit per valid cycle, done_o and
// word_o present the completed word combinationally in the cycle of the last bit.
module bus_bit_deser #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         bit_i,
    input  logic         valid_i,
    input  logic         clr_i,
    output logic [W-1:0] word_o,
    output logic         done_o
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    logic [W-1:0]  sh_q, sh_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        done_o = 1'b0;
        if (clr_i) begin
            sh_d  = '0;
            cnt_d = '0;
        end else if (valid_i) begin
            sh_d[cnt_q] = bit_i;
            if (cnt_q == CNT_LAST) begin
                done_o = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        word_o = sh_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/target_port.sv
// Responder end of the bit-serial bus: address/write-data deserialise, window
// decode, read-data serialise. Optional split support under TARGET_SPLIT_EN.
//
// state | meaning
// IDLE  | collecting address bits, decode on the 16th
// WDATA | collecting write-data bits; an address bit aborts
// RWAIT | waiting for local read data and initiator ready
// SPLIT | read released from the bus, waiting for data and re-grant
// RTX   | shifting 8 read-data bits out, ack on the last
module target_port
    import serial_bus_pkg::*;
#(
    parameter int                ADDR_W   = BUS_ADDR_W,
    parameter int                DATA_W   = BUS_DATA_W,
    parameter logic [ADDR_W-1:0] TGT_BASE = 16'h0000,
    parameter logic [ADDR_W-1:0] TGT_MASK = 16'hF000
`ifdef TARGET_SPLIT_EN
   ,parameter int                SPLIT_TIMEOUT = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_bus_if.slave       bus,
    input  logic [DATA_W-1:0] tgt_rdata,
    input  logic              tgt_rdata_valid,
    output logic [ADDR_W-1:0] tgt_addr,
    output logic              tgt_addr_valid,
    output logic              tgt_rw,
    output logic [DATA_W-1:0] tgt_wdata,
    output logic              tgt_wdata_valid
);

    localparam int TXW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [TXW-1:0] TX_LAST = TXW'(DATA_W - 1);

    tgt_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic              addr_vld_q, addr_vld_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wdata_vld_q, wdata_vld_d;
    logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
    logic              held_q, held_d;
    logic [TXW-1:0]    tx_cnt_q, tx_cnt_d;
    logic              split_q, split_d;
`ifdef TARGET_SPLIT_EN
    logic [7:0]        wait_cnt_q, wait_cnt_d;
`endif

    logic              addr_take, data_take, wr_abort;
    logic              addr_done, data_done;
    logic [ADDR_W-1:0] addr_word;
    logic [DATA_W-1:0] data_word;

    assign addr_take = bus.bus_data_in_valid && (bus.bus_mode == MODE_ADDR)
                       && ((state_q == IDLE) || (state_q == WDATA));
    assign data_take = bus.bus_data_in_valid && (bus.bus_mode == MODE_DATA)
                       && (state_q == WDATA);
    // An address bit during write data restarts the transaction; the address
    // collector is already at bit 0 here because it wrapped on the last decode.
    assign wr_abort  = (state_q == WDATA) && addr_take;

    bus_bit_deser #(.W(ADDR_W)) u_addr_deser (
        .clk     (clk),
        .rst_n   (rst_n),
        .bit_i   (bus.bus_data_in),
        .valid_i (addr_take),
        .clr_i   (1'b0),
        .word_o  (addr_word),
        .done_o  (addr_done)
    );

    bus_bit_deser #(.W(DATA_W)) u_data_deser (
        .clk     (clk),
        .rst_n   (rst_n),
        .bit_i   (bus.bus_data_in),
        .valid_i (data_take),
        .clr_i   (wr_abort),
        .word_o  (data_word),
        .done_o  (data_done)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        addr_vld_d  = 1'b0;
        wdata_d     = wdata_q;
        wdata_vld_d = 1'b0;
        rd_buf_d    = rd_buf_q;
        held_d      = held_q;
        tx_cnt_d    = tx_cnt_q;
        split_d     = 1'b0;
`ifdef TARGET_SPLIT_EN
        wait_cnt_d  = wait_cnt_q;
`endif

        if (((state_q == RWAIT) || (state_q == SPLIT)) && tgt_rdata_valid) begin
            rd_buf_d = tgt_rdata;
            held_d   = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (addr_done && ((addr_word & TGT_MASK) == TGT_BASE)) begin
                    addr_d     = addr_word;
                    rw_d       = bus.bus_init_rw;
                    addr_vld_d = 1'b1;
                    held_d     = 1'b0;
                    tx_cnt_d   = '0;
`ifdef TARGET_SPLIT_EN
                    wait_cnt_d = '0;
`endif
                    state_d    = (bus.bus_init_rw == RW_WRITE) ? WDATA : RWAIT;
                end
            end
            WDATA: begin
                if (wr_abort) begin
                    state_d = IDLE;
                end else if (data_done) begin
                    wdata_d     = data_word;
                    wdata_vld_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            RWAIT: begin
                if (held_d && bus.bus_init_ready) begin
                    state_d = RTX;
`ifdef TARGET_SPLIT_EN
                end else if (!held_d) begin
                    // Data arriving in the timeout cycle takes priority over the split.
                    if (wait_cnt_q == 8'(SPLIT_TIMEOUT - 1)) begin
                        split_d = 1'b1;
                        state_d = SPLIT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
`endif
                end
            end
`ifdef TARGET_SPLIT_EN
            SPLIT: begin
                if (held_d && bus.split_resume && bus.bus_init_ready) begin
                    state_d = RTX;
                end
            end
`endif
            RTX: begin
                if (tx_cnt_q == TX_LAST) begin
                    tx_cnt_d = '0;
                    held_d   = 1'b0;
                    state_d  = IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            addr_vld_q  <= 1'b0;
            wdata_q     <= '0;
            wdata_vld_q <= 1'b0;
            rd_buf_q    <= '0;
            held_q      <= 1'b0;
            tx_cnt_q    <= '0;
            split_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            addr_vld_q  <= addr_vld_d;
            wdata_q     <= wdata_d;
            wdata_vld_q <= wdata_vld_d;
            rd_buf_q    <= rd_buf_d;
            held_q      <= held_d;
            tx_cnt_q    <= tx_cnt_d;
            split_q     <= split_d;
        end
    end

`ifdef TARGET_SPLIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign bus.target_split = split_q;
`else
    logic unused_split;
    assign unused_split     = bus.split_resume ^ split_q;
    assign bus.target_split = 1'b0;
`endif

    assign tgt_addr           = addr_q;
    assign tgt_addr_valid     = addr_vld_q;
    assign tgt_rw             = rw_q;
    assign tgt_wdata          = wdata_q;
    assign tgt_wdata_valid    = wdata_vld_q;
    assign bus.bus_data_out_valid = (state_q == RTX);
    assign bus.bus_data_out   = (state_q == RTX) && rd_buf_q[tx_cnt_q];
    assign bus.target_ack     = wdata_vld_q || ((state_q == RTX) && (tx_cnt_q == TX_LAST));

endmodule
